sphere3_sched: RTL and testbench

Round-robin scheduler that shares one 3-sphere point generator (pop/reseed/valid interface, 32-bit w/x/y/z outputs) among NUM_REQ requesters. It issues single-cycle pops and waits for the generator's valid flag, with a watchdog timeout. It returns each 4-tuple on a shared response bus tagged with the requester index. It also serialises reseed requests from a configuration port so they never collide with an in-flight pop.

---
 rtl/sphere3_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_sphere3_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sphere3_sched.sv
// sphere3_sched
// Round-robin scheduler sharing one 3-sphere point generator among NUM_REQ
// requesters. It issues single-cycle pops and waits for gen_valid, with a
// watchdog timeout. Each captured w/x/y/z tuple is returned on a shared
// response bus tagged with the requester index. Reseed requests from the
// configuration port are serialised so they never overlap an in-flight pop.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req[NUM_REQ]        level requests, held until the matching rsp_valid
//   grant[NUM_REQ]      one-hot current owner (ISSUE/WAIT/DELIVER)
//   rsp_valid/rsp_id    one-cycle response strobe and requester index
//   rsp_w/x/y/z         captured generator outputs (hold between pulses)
//   cfg_reseed/cfg_seed reseed request pulse and seed value
//   gen_pop/gen_reseed  single-cycle strobes to the generator
//   gen_seed            seed presented with gen_reseed
//   gen_w/x/y/z,
//   gen_valid           generator outputs
//   busy                not idle, or a reseed is pending
//   err_timeout         sticky watchdog flag
//   sample_count        responses delivered, wrapping 32-bit
module sphere3_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [31:0]                rsp_w,
  output logic [31:0]                rsp_x,
  output logic [31:0]                rsp_y,
  output logic [31:0]                rsp_z,
  input  logic                       cfg_reseed,
  input  logic [31:0]                cfg_seed,
  output logic                       gen_pop,
  output logic                       gen_reseed,
  output logic [31:0]                gen_seed,
  input  logic [31:0]                gen_w,
  input  logic [31:0]                gen_x,
  input  logic [31:0]                gen_y,
  input  logic [31:0]                gen_z,
  input  logic                       gen_valid,
  output logic                       busy,
  output logic                       err_timeout,
  output logic [31:0]                sample_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_RESEED, S_SETTLE, S_ISSUE, S_WAIT, S_DELIVER
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pending_q, pending_d;
  logic [31:0]        seed_q, seed_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_w_q, rsp_w_d, rsp_x_q, rsp_x_d;
  logic [31:0]        rsp_y_q, rsp_y_d, rsp_z_q, rsp_z_d;
  logic               gen_pop_q, gen_pop_d;
  logic               gen_reseed_q, gen_reseed_d;
  logic [31:0]        gen_seed_q, gen_seed_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [31:0]        sample_count_q, sample_count_d;

  // Cyclic priority scan: first set request at or after the rr pointer.
  logic              found;
  logic [ID_W-1:0]   pick;
  logic [ID_W:0]     cand;
  logic [ID_W-1:0]   owner_inc;

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(i);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[ID_W-1:0];
      end
    end
  end

  assign owner_inc = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    pending_d      = pending_q;
    seed_d         = seed_q;
    gen_seed_d     = gen_seed_q;
    rsp_id_d       = rsp_id_q;
    rsp_w_d        = rsp_w_q;
    rsp_x_d        = rsp_x_q;
    rsp_y_d        = rsp_y_q;
    rsp_z_d        = rsp_z_q;
    err_d          = err_q;
    sample_count_d = sample_count_q;

    case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          // A seed arriving in the decision cycle is the newest one; use it
          // directly so the single reseed carries the latest value.
          gen_seed_d = cfg_reseed ? cfg_seed : seed_q;
          pending_d  = 1'b0;
          state_d    = S_RESEED;
        end else if (found) begin
          owner_d = pick;
          state_d = S_ISSUE;
        end
      end
      S_RESEED: state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gen_valid) begin
          rsp_id_d       = owner_q;
          rsp_w_d        = gen_w;
          rsp_x_d        = gen_x;
          rsp_y_d        = gen_y;
          rsp_z_d        = gen_z;
          sample_count_d = sample_count_q + 32'd1;
          rr_d           = owner_inc;
          state_d        = S_DELIVER;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort without a response; the requester keeps its req raised.
          err_d   = 1'b1;
          rr_d    = owner_inc;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DELIVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (cfg_reseed) begin
      seed_d = cfg_seed;
      // In the decision cycle the new seed is absorbed by the reseed
      // being launched, so it must not leave a second one pending.
      if (!(state_q == S_IDLE && pending_q)) pending_d = 1'b1;
    end

    // Strobes and grant are registered from the next state so they line
    // up with the state they belong to.
    gen_pop_d    = (state_d == S_ISSUE);
    gen_reseed_d = (state_d == S_RESEED);
    rsp_valid_d  = (state_d == S_DELIVER);
    busy_d       = (state_d != S_IDLE) || pending_d;
    grant_d      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_d[i] = ((state_d == S_ISSUE) || (state_d == S_WAIT) ||
                    (state_d == S_DELIVER)) && (owner_d == ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= '0;
      rr_q           <= '0;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      seed_q         <= '0;
      grant_q        <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= '0;
      rsp_w_q        <= '0;
      rsp_x_q        <= '0;
      rsp_y_q        <= '0;
      rsp_z_q        <= '0;
      gen_pop_q      <= 1'b0;
      gen_reseed_q   <= 1'b0;
      gen_seed_q     <= '0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_q           <= rr_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      seed_q         <= seed_d;
      grant_q        <= grant_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_w_q        <= rsp_w_d;
      rsp_x_q        <= rsp_x_d;
      rsp_y_q        <= rsp_y_d;
      rsp_z_q        <= rsp_z_d;
      gen_pop_q      <= gen_pop_d;
      gen_reseed_q   <= gen_reseed_d;
      gen_seed_q     <= gen_seed_d;
      busy_q         <= busy_d;
      err_q          <= err_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign grant        = grant_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_w        = rsp_w_q;
  assign rsp_x        = rsp_x_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_z        = rsp_z_q;
  assign gen_pop      = gen_pop_q;
  assign gen_reseed   = gen_reseed_q;
  assign gen_seed     = gen_seed_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;
  assign sample_count = sample_count_q;

endmodule

// File: tb/tb_sphere3_sched.sv
// Directed testbench for sphere3_sched (NUM_REQ=4, TIMEOUT=64).
// A small generator model answers each gen_pop after gen_lat cycles.
module tb_sphere3_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  grant;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_w, rsp_x, rsp_y, rsp_z;
  logic        cfg_reseed;
  logic [31:0] cfg_seed;
  logic        gen_pop, gen_reseed;
  logic [31:0] gen_seed;
  logic [31:0] gen_w, gen_x, gen_y, gen_z;
  logic        gen_valid;
  logic        busy, err_timeout;
  logic [31:0] sample_count;

  logic fire_valid = 1'b0;
  logic spur_valid = 1'b0;
  assign gen_valid = fire_valid | spur_valid;

  always #5 clk = ~clk;

  sphere3_sched #(.NUM_REQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .grant(grant),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_w(rsp_w), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .cfg_reseed(cfg_reseed), .cfg_seed(cfg_seed),
    .gen_pop(gen_pop), .gen_reseed(gen_reseed), .gen_seed(gen_seed),
    .gen_w(gen_w), .gen_x(gen_x), .gen_y(gen_y), .gen_z(gen_z),
    .gen_valid(gen_valid), .busy(busy), .err_timeout(err_timeout),
    .sample_count(sample_count)
  );

  int checks = 0;
  int errors = 0;

  // Event counters sampled mid-cycle.
  int n_pop = 0, n_reseed = 0, n_rsp = 0, n_bad = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (gen_pop) n_pop++;
      if (gen_reseed) n_reseed++;
      if (rsp_valid) n_rsp++;
      if (grant != 4'b0 && !$onehot(grant)) n_bad++;
      if (gen_pop && gen_reseed) n_bad++;
    end
  end

  // Generator model: valid arrives gen_lat cycles after the pop cycle.
  int gen_lat = 6;
  bit gen_never = 1'b0;
  int pend = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fire_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) fire_valid = 1'b1;
      end
      if (gen_pop && !gen_never) pend = gen_lat;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return rsp_valid;
      1: return gen_pop;
      2: return gen_reseed;
      default: return err_timeout;
    endcase
  endfunction

  // Bounded wait; cyc = ticks until the event, or -1 if it never came.
  task automatic wait_for(input int which, input int limit, output int cyc);
    cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      tick();
      if (sel(which)) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    int base;
    rst = 1'b1; req = 4'b0; cfg_reseed = 1'b0; cfg_seed = 32'h0;
    gen_w = 32'h11111111; gen_x = 32'h22222222;
    gen_y = 32'h33333333; gen_z = 32'h44444444;
    repeat (3) tick();
    chk("rst_grant", grant, 4'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_gen_pop", gen_pop, 1'b0);
    chk("rst_gen_reseed", gen_reseed, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_count", sample_count, 32'h0);
    chk("rst_seed", gen_seed, 32'h0);
    rst = 1'b0;
    tick();

    // Single requester, L=6: the response occupies the 9th cycle counting
    // the one where req is first presented (8 edges later).
    base = n_pop;
    gen_lat = 6;
    req = 4'b0001;
    wait_for(0, 40, cyc);
    chk("t1_latency", cyc, 8);
    chk("t1_id", rsp_id, 2'd0);
    chk("t1_w", rsp_w, 32'h11111111);
    chk("t1_x", rsp_x, 32'h22222222);
    chk("t1_y", rsp_y, 32'h33333333);
    chk("t1_z", rsp_z, 32'h44444444);
    chk("t1_count", sample_count, 32'd1);
    req = 4'b0;
    tick(); tick();
    chk("t1_pops", n_pop - base, 1);
    chk("t1_pulse", rsp_valid, 1'b0);
    chk("t1_hold", rsp_w, 32'h11111111);

    // Fairness with all requesters active.
    do_reset();
    gen_lat = 2;
    base = n_bad;
    req = 4'hF;
    for (int k = 0; k < 8; k++) begin
      wait_for(0, 20, cyc);
      chk($sformatf("t2_id%0d", k), rsp_id, 32'(k % 4));
      if (k == 7) req = 4'b0;
    end
    tick();
    chk("t2_onehot", n_bad - base, 0);
    chk("t2_count", sample_count, 32'd8);

    // Reseed requested twice while a pop is in flight.
    do_reset();
    gen_lat = 6;
    req = 4'b0010;
    wait_for(1, 10, cyc);
    chk("t3_pop_seen", cyc > 0, 1'b1);
    tick();
    cfg_reseed = 1'b1; cfg_seed = 32'hA5;
    tick();
    cfg_seed = 32'h5A;
    tick();
    cfg_reseed = 1'b0; cfg_seed = 32'h0;
    chk("t3_busy", busy, 1'b1);
    base = n_reseed;
    wait_for(0, 20, cyc);
    chk("t3_rsp_id", rsp_id, 2'd1);
    chk("t3_reseed_before_rsp", n_reseed - base, 0);
    req = 4'b0;
    wait_for(2, 10, cyc);
    chk("t3_reseed_seen", cyc > 0, 1'b1);
    chk("t3_seed", gen_seed, 32'h5A);
    chk("t3_no_pop_with_reseed", gen_pop, 1'b0);
    req = 4'b0100;
    wait_for(1, 10, cyc);
    chk("t3_reseed_to_pop", cyc, 3);
    wait_for(0, 20, cyc);
    chk("t3_rsp2_id", rsp_id, 2'd2);
    req = 4'b0;
    tick(); tick();
    chk("t3_one_reseed", n_reseed - base, 1);

    // Watchdog timeout on requester 2, then re-issue to requester 3.
    do_reset();
    gen_never = 1'b1;
    req = 4'b0100;
    wait_for(1, 10, cyc);
    chk("t4_pop_seen", cyc > 0, 1'b1);
    chk("t4_grant", grant, 4'b0100);
    base = n_rsp;
    wait_for(3, 100, cyc);
    chk("t4_timeout_cycles", cyc, 65);
    chk("t4_err", err_timeout, 1'b1);
    chk("t4_no_rsp", rsp_valid, 1'b0);
    chk("t4_grant_idle", grant, 4'b0);
    req = 4'b1100;
    gen_never = 1'b0;
    gen_lat = 2;
    wait_for(1, 10, cyc);
    chk("t4_reissue_grant", grant, 4'b1000);
    wait_for(0, 10, cyc);
    chk("t4_rsp_id3", rsp_id, 2'd3);
    req = 4'b0100;
    wait_for(0, 20, cyc);
    chk("t4_rsp_id2", rsp_id, 2'd2);
    req = 4'b0;
    tick();
    chk("t4_rsp_total", n_rsp - base, 2);
    chk("t4_err_sticky", err_timeout, 1'b1);

    // Spurious gen_valid while idle.
    tick();
    base = n_rsp;
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    repeat (3) tick();
    chk("t5_spurious_rsp", n_rsp - base, 0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_count", sample_count, 32'd2);

    // Reset during WAIT with a reseed pending.
    gen_never = 1'b1;
    req = 4'b0001;
    wait_for(1, 10, cyc);
    chk("t5_pop_seen", cyc > 0, 1'b1);
    tick(); tick();
    cfg_reseed = 1'b1; cfg_seed = 32'hDEAD;
    tick();
    cfg_reseed = 1'b0; cfg_seed = 32'h0;
    chk("t5_wait_grant", grant, 4'b0001);
    chk("t5_wait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_rst_grant", grant, 4'b0);
    chk("t5_rst_pop", gen_pop, 1'b0);
    chk("t5_rst_reseed", gen_reseed, 1'b0);
    chk("t5_rst_rsp_valid", rsp_valid, 1'b0);
    chk("t5_rst_rsp_w", rsp_w, 32'h0);
    chk("t5_rst_rsp_id", rsp_id, 2'd0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_err", err_timeout, 1'b0);
    chk("t5_rst_count", sample_count, 32'h0);
    chk("t5_rst_seed", gen_seed, 32'h0);
    rst = 1'b0;
    req = 4'b0;
    base = n_reseed;
    repeat (5) tick();
    chk("t5_pending_dropped", n_reseed - base, 0);
    chk("t5_idle_busy", busy, 1'b0);

    // Counter wrap.
    force dut.sample_count_q = 32'hFFFFFFFF;
    tick();
    release dut.sample_count_q;
    tick();
    chk("t6_preload", sample_count, 32'hFFFFFFFF);
    gen_never = 1'b0;
    gen_lat = 1;
    req = 4'b0001;
    wait_for(0, 20, cyc);
    chk("t6_latency", cyc, 3);
    chk("t6_wrap", sample_count, 32'h0);
    req = 4'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
